// File: rtl/apu_frame_seq.sv
// APU frame sequencer: counts APU cycles from divider edges, emits quarter/half strobes and the frame IRQ.
// Optional feature macro: APU_FRAME_IRQ_EN enables the irq flag, inhibit bit and $4015-read acknowledge.
module apu_frame_seq #(
  parameter int unsigned STEP1 = 3729,
  parameter int unsigned STEP2 = 7457,
  parameter int unsigned STEP3 = 11186,
  parameter int unsigned STEP4 = 14915,
  parameter int unsigned STEP5 = 18641,
  parameter int unsigned W     = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         div_out,
  input  logic         wr_en,
  input  logic [7:0]   wr_data,
  input  logic         rd_status,
  output logic         quarter,
  output logic         half,
  output logic         irq,
  output logic [W-1:0] cnt
);

  logic         prev_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic         mode_q, mode_d;
  logic         pending_q, pending_d;
  logic         quarter_q, quarter_d;
  logic         half_q, half_d;
  logic         tick;
  logic         irq_set;
  logic         at1, at2, at3, at4, at5, at_last;
  logic         unused_ok;

  assign tick = div_out & ~prev_q;
  assign at1  = (cnt_q == W'(STEP1));
  assign at2  = (cnt_q == W'(STEP2));
  assign at3  = (cnt_q == W'(STEP3));
  assign at4  = (cnt_q == W'(STEP4));
  assign at5  = (cnt_q == W'(STEP5));
  assign unused_ok = ^wr_data[5:0];

  // A pending $4017 write takes over the next tick: restart the frame instead of evaluating steps.
  always_comb begin
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    pending_d = pending_q;
    quarter_d = 1'b0;
    half_d    = 1'b0;
    irq_set   = 1'b0;
    at_last   = mode_q ? at5 : at4;
    if (tick) begin
      if (pending_q) begin
        cnt_d     = '0;
        pending_d = 1'b0;
        quarter_d = mode_q;
        half_d    = mode_q;
      end else begin
        quarter_d = at1 | at2 | at3 | at_last;
        half_d    = at2 | at_last;
        irq_set   = ~mode_q & at4;
        cnt_d     = at_last ? '0 : cnt_q + W'(1);
      end
    end
    if (wr_en) begin
      mode_d    = wr_data[7];
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      pending_q <= 1'b0;
      quarter_q <= 1'b0;
      half_q    <= 1'b0;
    end else begin
      prev_q    <= div_out;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      quarter_q <= quarter_d;
      half_q    <= half_d;
    end
  end

`ifdef APU_FRAME_IRQ_EN
  logic inhibit_q, inhibit_d;
  logic irq_q, irq_d;

  // Priority, lowest to highest: acknowledge, step-4 set, inhibit write.
  always_comb begin
    inhibit_d = inhibit_q;
    irq_d     = irq_q;
    if (rd_status) irq_d = 1'b0;
    if (irq_set & ~inhibit_q) irq_d = 1'b1;
    if (wr_en) begin
      inhibit_d = wr_data[6];
      if (wr_data[6]) irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      inhibit_q <= inhibit_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = ^{irq_set, rd_status, wr_data[6]};
  assign irq        = 1'b0;
`endif

  assign quarter = quarter_q;
  assign half    = half_q;
  assign cnt     = cnt_q;

endmodule

// File: tb/tb_apu_frame_seq.sv
// Self-checking bench for apu_frame_seq with small step counts; a cycle model feeds a scoreboard queue.
module tb_apu_frame_seq;
  localparam int unsigned W = 5;
`ifdef APU_FRAME_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         div_out = 1'b0;
  logic         wr_en = 1'b0;
  logic [7:0]   wr_data = 8'h00;
  logic         rd_status = 1'b0;
  logic         quarter, half, irq;
  logic [W-1:0] cnt;

  apu_frame_seq #(
    .STEP1(3), .STEP2(6), .STEP3(9), .STEP4(12), .STEP5(15), .W(W)
  ) dut (
    .clk(clk), .reset(reset), .div_out(div_out), .wr_en(wr_en), .wr_data(wr_data),
    .rd_status(rd_status), .quarter(quarter), .half(half), .irq(irq), .cnt(cnt)
  );

  typedef struct packed {
    logic         q;
    logic         h;
    logic         i;
    logic [W-1:0] c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic m_prev = 1'b0, m_mode = 1'b0, m_inh = 1'b0, m_pend = 1'b0, m_irq = 1'b0;
  int   m_cnt = 0;
  logic         t_q, t_h, t_i;
  logic [W-1:0] t_c;

  task automatic cycle();
    logic tick, set, nq, nh, nirq;
    int   ncnt, last;
    int   qs[4];
    int   hs[2];
    exp_t e, got;
    nq = 1'b0;
    nh = 1'b0;
    if (reset) begin
      m_prev = 1'b0; m_mode = 1'b0; m_inh = 1'b0; m_pend = 1'b0; m_irq = 1'b0; m_cnt = 0;
    end else begin
      tick = div_out && !m_prev;
      set  = 1'b0;
      ncnt = m_cnt;
      last = m_mode ? 15 : 12;
      qs   = '{3, 6, 9, last};
      hs   = '{6, last};
      if (tick && m_pend) begin
        ncnt = 0; nq = m_mode; nh = m_mode; m_pend = 1'b0;
      end else if (tick) begin
        for (int k = 0; k < 4; k++) if (m_cnt == qs[k]) nq = 1'b1;
        for (int k = 0; k < 2; k++) if (m_cnt == hs[k]) nh = 1'b1;
        set  = (m_mode == 1'b0) && (m_cnt == 12);
        ncnt = (m_cnt == last) ? 0 : m_cnt + 1;
      end
      nirq = m_irq;
      if (rd_status) nirq = 1'b0;
      if (set && !m_inh) nirq = 1'b1;
      if (wr_en) begin
        m_mode = wr_data[7]; m_inh = wr_data[6]; m_pend = 1'b1;
        if (wr_data[6]) nirq = 1'b0;
      end
      m_irq  = nirq & IRQ_ON;
      m_cnt  = ncnt;
      m_prev = div_out;
    end
    e.q = nq; e.h = nh; e.i = m_irq; e.c = W'(m_cnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checks += 4;
    if (quarter !== got.q) begin errors++; $display("FAIL sb_quarter got %b exp %b at %0t", quarter, got.q, $time); end
    if (half !== got.h)    begin errors++; $display("FAIL sb_half got %b exp %b at %0t", half, got.h, $time); end
    if (irq !== got.i)     begin errors++; $display("FAIL sb_irq got %b exp %b at %0t", irq, got.i, $time); end
    if (cnt !== got.c)     begin errors++; $display("FAIL sb_cnt got %0d exp %0d at %0t", cnt, got.c, $time); end
  endtask

  task automatic drive(input logic d, input logic w, input logic [7:0] wd, input logic r);
    div_out = d; wr_en = w; wr_data = wd; rd_status = r;
    cycle();
  endtask

  task automatic tick_once(input logic w, input logic [7:0] wd, input logic r);
    drive(1'b1, w, wd, r);
    t_q = quarter; t_h = half; t_i = irq; t_c = cnt;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic write_low(input logic [7:0] wd);
    drive(1'b0, 1'b1, wd, 1'b0);
    wr_en = 1'b0;
  endtask

  task automatic run_until(input int target);
    int n = 0;
    while (m_cnt != target && n < 40) begin
      tick_once(1'b0, 8'h00, 1'b0);
      n++;
    end
    checks++;
    if (cnt !== W'(target)) begin errors++; $display("FAIL run_until got %0d exp %0d", cnt, target); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    checks++;
    if ({quarter, half, irq, cnt} !== '0) begin
      errors++; $display("FAIL reset_state got q%b h%b i%b c%0d exp all 0", quarter, half, irq, cnt);
    end
  endtask

  task automatic test_four_step();
    int nq = 0, nh = 0;
    for (int t = 0; t < 26; t++) begin
      tick_once(1'b0, 8'h00, 1'b0);
      nq += int'(t_q); nh += int'(t_h);
    end
    checks += 4;
    if (nq != 8) begin errors++; $display("FAIL four_step_quarters got %0d exp 8", nq); end
    if (nh != 4) begin errors++; $display("FAIL four_step_halves got %0d exp 4", nh); end
    if (cnt !== '0) begin errors++; $display("FAIL four_step_wrap got %0d exp 0", cnt); end
    if (irq !== IRQ_ON) begin errors++; $display("FAIL four_step_irq got %b exp %b", irq, IRQ_ON); end
  endtask

  task automatic test_irq_ack();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_ack got %b exp 0", irq); end
    run_until(12);
    tick_once(1'b0, 8'h00, 1'b1);
    checks++;
    if (t_i !== IRQ_ON) begin errors++; $display("FAIL irq_set_over_ack got %b exp %b", t_i, IRQ_ON); end
  endtask

  task automatic test_mode5();
    int nq = 0, nh = 0;
    logic any_irq = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    run_until(5);
    write_low(8'h80);
    tick_once(1'b0, 8'h00, 1'b0);
    checks++;
    if ({t_c, t_q, t_h} !== {W'(0), 2'b11}) begin
      errors++; $display("FAIL mode5_restart got c%0d q%b h%b exp c0 q1 h1", t_c, t_q, t_h);
    end
    for (int t = 0; t < 16; t++) begin
      tick_once(1'b0, 8'h00, 1'b0);
      nq += int'(t_q); nh += int'(t_h); any_irq |= t_i;
    end
    checks += 4;
    if (nq != 4) begin errors++; $display("FAIL mode5_quarters got %0d exp 4", nq); end
    if (nh != 2) begin errors++; $display("FAIL mode5_halves got %0d exp 2", nh); end
    if (any_irq !== 1'b0) begin errors++; $display("FAIL mode5_irq got %b exp 0", any_irq); end
    if (cnt !== '0) begin errors++; $display("FAIL mode5_wrap got %0d exp 0", cnt); end
  endtask

  task automatic test_inhibit();
    int nq = 0;
    logic any_irq = 1'b0;
    write_low(8'h00);
    tick_once(1'b0, 8'h00, 1'b0);
    run_until(12);
    tick_once(1'b0, 8'h00, 1'b0);
    checks++;
    if (t_i !== IRQ_ON) begin errors++; $display("FAIL inhibit_pre_irq got %b exp %b", t_i, IRQ_ON); end
    write_low(8'h40);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL inhibit_clear got %b exp 0", irq); end
    for (int t = 0; t < 14; t++) begin
      tick_once(1'b0, 8'h00, 1'b0);
      nq += int'(t_q); any_irq |= t_i;
    end
    checks += 2;
    if (any_irq !== 1'b0) begin errors++; $display("FAIL inhibit_no_irq got %b exp 0", any_irq); end
    if (nq != 4) begin errors++; $display("FAIL inhibit_quarters got %0d exp 4", nq); end
  endtask

  task automatic test_write_on_tick();
    run_until(3);
    tick_once(1'b1, 8'h00, 1'b0);
    checks += 2;
    if (t_q !== 1'b1) begin errors++; $display("FAIL wot_quarter got %b exp 1", t_q); end
    if (t_c !== W'(4)) begin errors++; $display("FAIL wot_cnt got %0d exp 4", t_c); end
    tick_once(1'b0, 8'h00, 1'b0);
    checks++;
    if ({t_c, t_q, t_h} !== {W'(0), 2'b00}) begin
      errors++; $display("FAIL wot_restart got c%0d q%b h%b exp c0 q0 h0", t_c, t_q, t_h);
    end
  endtask

  task automatic test_reset_mid();
    write_low(8'h00);
    tick_once(1'b0, 8'h00, 1'b0);
    run_until(8);
    write_low(8'h80);
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    checks++;
    if ({quarter, half, irq, cnt} !== '0) begin
      errors++; $display("FAIL reset_mid got q%b h%b i%b c%0d exp all 0", quarter, half, irq, cnt);
    end
    test_four_step();
  endtask

  initial begin
    test_reset();
    test_four_step();
    test_irq_ack();
    test_mode5();
    test_inhibit();
    test_write_on_tick();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
